// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg
// Shared defaults and width helpers for the IF->ID instruction queue.
// The entry/interface widths are the concatenation {pc, inst}.
package id_inst_queue_pkg;

    localparam int IQ_DEF_DEPTH  = 4;
    localparam int IQ_DEF_PC_W   = 32;
    localparam int IQ_DEF_INST_W = 32;

    // Width of one stored queue entry {pc, inst}.
    function automatic int iq_entry_wd(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

    // Width of the IF->IQ payload (same packing as a stored entry).
    function automatic int if_to_iq_wd(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

    // Width of the IQ->ID payload (same packing as a stored entry).
    function automatic int iq_to_id_wd(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

endpackage

// File: rtl/id_inst_queue_iq_ram.sv
// iq_ram
// DEPTH x WD register array used as instruction-queue storage.
// One synchronous write port, one asynchronous read port, storage not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational from raddr_i)
module iq_ram #(
    parameter int DEPTH = 4,
    parameter int WD    = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WD-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WD-1:0]            rdata_o
);

    logic [WD-1:0] mem_q [DEPTH];

    // Storage write port; contents deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_inst_queue.sv
// id_inst_queue
// Instruction queue between IF and ID. Captures each fetched {pc, inst}
// pair and hands it to ID under a valid/ready handshake. A synchronous
// flush drops everything (including a push in the same cycle). almost_full
// gives IF early warning to cover the instruction SRAM read latency.
//
// Optional feature (macro ID_IQ_BYPASS_EN): when the queue is empty an
// incoming instruction is presented to ID in the same cycle; if ID takes
// it, it is never written into storage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard all entries and any same-cycle push
//   in_valid/in_pc/in_inst/in_ready     IF side push handshake
//   out_valid/out_pc/out_inst/out_ready ID side pop handshake
//   count               current occupancy
//   almost_full         count >= AF_LEVEL
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH    = IQ_DEF_DEPTH,
    parameter int PC_W     = IQ_DEF_PC_W,
    parameter int INST_W   = IQ_DEF_INST_W,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_inst,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = iq_entry_wd(PC_W, INST_W);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] AF_LVL  = (AW + 1)'(AF_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] rd_entry_s;
    logic [EW-1:0] head_entry_s;

    assign empty_s = (wp_q == rp_q);
    assign full_s  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

    // Status outputs depend only on pointer registers.
    assign in_ready    = ~full_s;
    assign count       = wp_q - rp_q;
    assign almost_full = (count >= AF_LVL);

`ifdef ID_IQ_BYPASS_EN
    logic byp_s;

    // Empty queue: forward the incoming pair straight to ID.
    assign byp_s        = empty_s & in_valid & ~flush;
    assign out_valid    = ~empty_s | byp_s;
    assign head_entry_s = empty_s ? {in_pc, in_inst} : rd_entry_s;
    // A bypassed pair that ID consumes immediately is never stored.
    assign push_s       = in_valid & ~full_s & ~flush & ~(byp_s & out_ready);
`else
    assign out_valid    = ~empty_s;
    assign head_entry_s = rd_entry_s;
    assign push_s       = in_valid & ~full_s & ~flush;
`endif

    // Only stored entries advance the read pointer; a bypass consume does not.
    assign pop_s = ~empty_s & out_ready & ~flush;

    assign out_pc   = head_entry_s[EW-1:INST_W];
    assign out_inst = head_entry_s[INST_W-1:0];

    iq_ram #(
        .DEPTH (DEPTH),
        .WD    (EW)
    ) u_iq_ram (
        .clk_i   (clk),
        .we_i    (push_s),
        .waddr_i (wp_q[AW-1:0]),
        .wdata_i ({in_pc, in_inst}),
        .raddr_i (rp_q[AW-1:0]),
        .rdata_o (rd_entry_s)
    );

    // Next-state pointers: flush clears both, else push/pop advance independently.
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (push_s) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop_s) begin
                rp_d = rp_q + PTR_ONE;
            end else begin
                rp_d = rp_q;
            end
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue
// Self-checking bench for id_inst_queue (DEPTH=4, 32-bit pc/inst).
// A queue-based model tracks expected contents; a negedge process compares
// every DUT output each cycle. Directed sequences add literal expectations.
module tb_id_inst_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [2:0]        count;
    logic              almost_full;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [63:0] model_q [$];

    id_inst_queue #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .AF_LEVEL (DEPTH - 1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare, then model update for the coming edge.
    always @(negedge clk) begin
        int  sz;
        bit  exp_valid;
        bit  do_push;
        bit  do_pop;
        logic [63:0] head;
        sz = model_q.size();
        if (check_en) begin
            exp_valid = (sz > 0);
            head = (sz > 0) ? model_q[0] : 64'd0;
`ifdef ID_IQ_BYPASS_EN
            if (sz == 0 && in_valid && !flush) begin
                exp_valid = 1'b1;
                head = {in_pc, in_inst};
            end
`endif
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("m_count", {61'd0, count}, 64'(sz));
            chk("m_almost_full", {63'd0, almost_full}, {63'd0, (sz >= DEPTH - 1)});
            chk("m_in_ready", {63'd0, in_ready}, {63'd0, (sz != DEPTH)});
            chk("m_in_ready_vs_count", {63'd0, in_ready}, {63'd0, (count != 3'(DEPTH))});
            if (exp_valid) begin
                chk("m_out_entry", {out_pc, out_inst}, head);
            end
        end
        if (rst || flush) begin
            model_q.delete();
        end else begin
            do_push = in_valid && (sz < DEPTH);
            do_pop  = (sz > 0) && out_ready;
`ifdef ID_IQ_BYPASS_EN
            if (sz == 0 && in_valid && out_ready) do_push = 1'b0;
`endif
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_pc, in_inst});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = pc ^ 32'h5A5A0000;
        out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0;
        in_inst = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        samp();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_almost_full", {63'd0, almost_full}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single push with ID ready
        step();
        in_valid = 1'b1; in_pc = 32'hBFC00000; in_inst = 32'h24080001; out_ready = 1'b1;
        samp();
`ifdef ID_IQ_BYPASS_EN
        chk("t1_byp_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_byp_pc", {32'd0, out_pc}, 64'hBFC00000);
`endif
        step();
        in_valid = 1'b0;
        samp();
`ifndef ID_IQ_BYPASS_EN
        chk("t1_valid_c2", {63'd0, out_valid}, 64'd1);
        chk("t1_pc_c2", {32'd0, out_pc}, 64'hBFC00000);
        chk("t1_inst_c2", {32'd0, out_inst}, 64'h24080001);
`endif
        step();
        samp();
        chk("t1_count_c3", {61'd0, count}, 64'd0);

        // Fill past capacity with ID stalled
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 32'(4 * i), 1'b0);
            samp();
            chk("t2_count", {61'd0, count}, 64'(i));
            chk("t2_in_ready", {63'd0, in_ready}, {63'd0, (i < 4)});
            chk("t2_almost_full", {63'd0, almost_full}, {63'd0, (i >= 3)});
        end
        step();
        drive(1'b0, 32'd0, 1'b0);
        samp();
        chk("t2_full_count", {61'd0, count}, 64'd4);
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            samp();
            chk("t2_pop_valid", {63'd0, out_valid}, 64'd1);
            chk("t2_pop_pc", {32'd0, out_pc}, 64'(4 * k));
            step();
        end
        samp();
        chk("t2_drained", {63'd0, out_valid}, 64'd0);

        // Steady occupancy 2 with push and pop together
        step();
        drive(1'b1, 32'h200, 1'b0);
        step();
        drive(1'b1, 32'h204, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            drive(1'b1, 32'(32'h208 + 4 * k), 1'b1);
            samp();
            chk("t3_count", {61'd0, count}, 64'd2);
            chk("t3_pc", {32'd0, out_pc}, 64'(32'h200 + 4 * k));
        end

        // Flush with a concurrent push at occupancy 3
        step();
        drive(1'b0, 32'd0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h300 + 4 * k), 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD0000, 1'b0);
        flush = 1'b1;
        samp();
        chk("t4_pre_count", {61'd0, count}, 64'd3);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        samp();
        chk("t4_count", {61'd0, count}, 64'd0);
        chk("t4_valid", {63'd0, out_valid}, 64'd0);
        step();
        drive(1'b1, 32'h310, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0);
        samp();
        chk("t4_next_pc", {32'd0, out_pc}, 64'h310);

        // Reset mid-operation at occupancy 2
        step();
        drive(1'b1, 32'h400, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0);
        samp();
        chk("t5_pre_count", {61'd0, count}, 64'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        samp();
        chk("t5_count", {61'd0, count}, 64'd0);
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        drive(1'b1, 32'h100, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0);
        samp();
        chk("t5_first_pc", {32'd0, out_pc}, 64'h100);

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 10000; n++) begin
            step();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            rst       = ($urandom % 997) == 0;
            in_pc     = $urandom;
            in_inst   = $urandom;
        end
        step();
        samp();
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
